processor_array_scan: RTL
=========================

PROCESSOR_ARRAY_SCAN -- requirements
Module: processor_array_scan

Interface
REQ-001 The block SHALL provide parameter XW, default 10, meaning the x-coordinate width.
REQ-002 The block SHALL provide parameter YW, default 10, meaning the y-coordinate width.
REQ-003 The block SHALL provide parameter FW, default 8, meaning the frame-counter width.
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 Port ena  input  1  SHALL mean advance enable; low stalls the scan.
REQ-007 Port start  input  1  SHALL mean begin a scan; sampled only in IDLE.
REQ-008 Port mode  input  2  SHALL select the order: 0 raster, 1 serpentine, 2 column-major, 3 treated as raster.
REQ-009 Port loop  input  1  SHALL mean wrap to (0,0) at frame end instead of finishing; sampled every cycle.
REQ-010 Port xlim  input  XW  SHALL be the inclusive maximum x, latched at start.
REQ-011 Port ylim  input  YW  SHALL be the inclusive maximum y, latched at start.
REQ-012 Port xpos  output  XW  SHALL be the current x coordinate.
REQ-013 Port ypos  output  YW  SHALL be the current y coordinate.
REQ-014 Port valid  output  1  SHALL mean xpos/ypos is issued this cycle (RUN and ena).
REQ-015 Port first / last  output  1 each  SHALL flag the first and last point of a frame; both are qualified by valid.
REQ-016 Port busy  output  1  SHALL be high in RUN and DONE.
REQ-017 Port done  output  1  SHALL be a one-cycle pulse in DONE.
REQ-018 Port frame_cnt  output  FW  SHALL count completed frames, wrapping modulo 2^FW.

Function
REQ-019 The state machine SHALL have the states IDLE, RUN and DONE.
REQ-020 Transitions: IDLE->RUN on start (mode, xlim and ylim latched, position (0,0)); RUN->DONE on a valid last point with loop=0; DONE->IDLE unconditionally.
REQ-021 The first valid point SHALL appear the cycle after start; the latency is 1.
REQ-022 In RUN with ena=0, position SHALL hold and valid SHALL be 0.
REQ-023 Raster order: x increments and wraps to 0 at xlim, at which point y increments.
REQ-024 Serpentine order: even rows run x ascending 0..xlim, odd rows run x descending xlim..0, and y increments at each row end.
REQ-025 Column-major order: y increments and wraps to 0 at ylim, at which point x increments.
REQ-026 last SHALL assert at the final point of the order: raster (xlim,ylim); column-major (xlim,ylim); serpentine (xlim,ylim) when ylim is even and (0,ylim) when ylim is odd.
REQ-027 A valid last point with loop=1 SHALL return the position to (0,0), keep the block in RUN, and raise first on the next valid point.
REQ-028 frame_cnt SHALL increment on every valid last point, whether looping or not.
REQ-029 With xlim=0 and ylim=0, every valid point SHALL assert both first and last.
REQ-030 start SHALL be ignored in RUN and DONE.
REQ-031 In DONE, xpos and ypos SHALL hold the last point and valid SHALL be 0.
REQ-032 Arithmetic: counters are unsigned, and no position SHALL exceed its latched limit.

Reset
REQ-033 rst low SHALL immediately force IDLE, xpos=0, ypos=0, valid=0, first=0, last=0, busy=0, done=0, frame_cnt=0 and latched mode=0, including mid-scan.
REQ-034 After rst deasserts, the block SHALL wait for a fresh start.

Structure
REQ-035 A shared package processor_array_pkg SHALL hold the mode encodings (MODE_RASTER, MODE_SERP, MODE_COL) and the state enum.
REQ-036 One sub-module scan_axis_cnt SHALL be instantiated per axis; each instance provides up/down count, limit compare, wrap and a terminal flag.

Verification
REQ-037 Raster, xlim=2, ylim=1, ena=1: start -> valid points (0,0)(1,0)(2,0)(0,1)(1,1)(2,1), first on (0,0), last on (2,1), then done for 1 cycle and frame_cnt=1.
REQ-038 Serpentine, xlim=2, ylim=1: sequence (0,0)(1,0)(2,0)(2,1)(1,1)(0,1), last on (0,1).
REQ-039 Column-major, xlim=1, ylim=2, with ena toggling 1,0,1,...: points (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), with valid low and position held during ena=0 cycles.
REQ-040 loop=1, xlim=0, ylim=0: every cycle point (0,0) with first=last=1, frame_cnt increments each cycle, wraps 255->0, and done is never asserted.
REQ-041 rst pulsed low at point (1,0) mid-scan -> outputs immediately return to reset values; start pulsed while busy is ignored; a fresh start restarts at (0,0).

Source files
------------

// File: rtl/processor_array_pkg.sv
// Shared encodings for the processor-array scan generator: scan-order modes
// and the controller state enum.
package processor_array_pkg;

    localparam logic [1:0] MODE_RASTER = 2'd0;
    localparam logic [1:0] MODE_SERP   = 2'd1;
    localparam logic [1:0] MODE_COL    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/scan_axis_cnt.sv
// One scan axis: up/down position counter with limit compare, optional wrap
// and a terminal flag (at lim counting up, at 0 counting down).
module scan_axis_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         step,
    input  logic         down,
    input  logic         wrap,
    input  logic [W-1:0] lim,
    output logic [W-1:0] cnt,
    output logic         term
);

    localparam logic [W-1:0] ONE = W'(1);

    assign term = down ? (cnt == '0) : (cnt == lim);

    // A step at the terminal either wraps to the opposite end or holds, so the
    // count can never leave 0..lim.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (step) begin
            if (term) begin
                if (wrap) cnt <= down ? lim : '0;
            end else begin
                cnt <= down ? (cnt - ONE) : (cnt + ONE);
            end
        end
    end

endmodule

// File: rtl/processor_array_scan.sv
// Scan-order generator for a 2-D processor array: issues (x,y) coordinates in
// raster, serpentine or column-major order, one point per enabled cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; position holds
// ST_RUN  | issuing points, one per cycle with ena high
// ST_DONE | one cycle after the final point; done pulses, position holds
module processor_array_scan
    import processor_array_pkg::*;
#(
    parameter int XW = 10,
    parameter int YW = 10,
    parameter int FW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          loop,
    input  logic [XW-1:0] xlim,
    input  logic [YW-1:0] ylim,
    output logic [XW-1:0] xpos,
    output logic [YW-1:0] ypos,
    output logic          valid,
    output logic          first,
    output logic          last,
    output logic          busy,
    output logic          done,
    output logic [FW-1:0] frame_cnt
);

    scan_state_e   state, state_nxt;
    logic [1:0]    mode_q;
    logic [XW-1:0] xlim_q;
    logic [YW-1:0] ylim_q;
    logic [FW-1:0] frame_q;

    logic adv, adv_mv, pt_last, clr;
    logic is_serp, is_col;
    logic x_step, x_down, x_wrap, x_term;
    logic y_step, y_term;

    assign is_serp = (mode_q == MODE_SERP);
    assign is_col  = (mode_q == MODE_COL);

    assign adv = (state == ST_RUN) && ena;

    // In every order the final point is where both axes sit at their terminal:
    // serpentine's x terminal flips with row parity, the others count x up.
    assign pt_last = x_term && y_term;
    assign adv_mv  = adv && !pt_last;
    assign clr     = ((state == ST_IDLE) && start) || (adv && pt_last && loop);

    always_comb begin
        x_down = 1'b0;
        x_wrap = 1'b1;
        x_step = adv_mv;
        y_step = adv_mv && x_term;
        if (is_col) begin
            x_step = adv_mv && y_term;
            y_step = adv_mv;
        end else if (is_serp) begin
            x_down = ypos[0];
            x_wrap = 1'b0;
            x_step = adv_mv && !x_term;
        end
    end

    scan_axis_cnt #(.W(XW)) u_x_axis (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .step (x_step),
        .down (x_down),
        .wrap (x_wrap),
        .lim  (xlim_q),
        .cnt  (xpos),
        .term (x_term)
    );

    scan_axis_cnt #(.W(YW)) u_y_axis (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .step (y_step),
        .down (1'b0),
        .wrap (1'b1),
        .lim  (ylim_q),
        .cnt  (ypos),
        .term (y_term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (adv && pt_last && !loop) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Mode 3 is folded into raster at latch time so decode only sees 0..2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_RASTER;
            xlim_q <= '0;
            ylim_q <= '0;
        end else if ((state == ST_IDLE) && start) begin
            mode_q <= (mode == 2'd3) ? MODE_RASTER : mode;
            xlim_q <= xlim;
            ylim_q <= ylim;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q <= '0;
        end else if (adv && pt_last) begin
            frame_q <= frame_q + FW'(1);
        end
    end

    assign valid     = adv;
    assign first     = adv && (xpos == '0) && (ypos == '0);
    assign last      = adv && pt_last;
    assign busy      = (state == ST_RUN) || (state == ST_DONE);
    assign done      = (state == ST_DONE);
    assign frame_cnt = frame_q;

endmodule
